// File: rtl/conv_encoder_stream.sv
// Rate-1/2 framed convolutional encoder (K, G0, G1 parameters); zero-tail termination when CONV_TAIL_EN is defined.
// Latency: a bit accepted on edge n gives its registered code pair in cycle n+1; one pair per cycle sustained.
// Backpressure: a held pair (out_valid && !out_ready) stalls input acceptance and tail generation.
module conv_encoder_stream #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic b0,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic c0,
    output logic c1,
    output logic out_last,
    output logic busy
);

`ifdef CONV_TAIL_EN
    localparam int TW = $clog2(K);
    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
    logic [TW-1:0] tcnt_q, tcnt_d;
`else
    typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;
`endif

    state_t         state_q, state_d;
    logic [K-2:0]   sr_q, sr_d;
    logic           out_valid_q, out_valid_d;
    logic           c0_q, c0_d;
    logic           c1_q, c1_d;
    logic           last_q, last_d;
    logic           out_free;
    logic           accept;
    logic [K-1:0]   enc_v;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = reset && ((state_q == IDLE) || (state_q == DATA)) && out_free;
    assign accept   = in_valid && in_ready;
    // Outside an accept (tail cycles) the encoded bit is a forced zero.
    assign enc_v    = {(accept ? b0 : 1'b0), sr_q};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        c0_d        = c0_q;
        c1_d        = c1_q;
        last_d      = last_q;
`ifdef CONV_TAIL_EN
        tcnt_d      = tcnt_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    c0_d        = ^(enc_v & G0);
                    c1_d        = ^(enc_v & G1);
                    out_valid_d = 1'b1;
                    last_d      = 1'b0;
                    sr_d        = {b0, sr_q[K-2:1]};
                    state_d     = DATA;
                    if (in_last) begin
`ifdef CONV_TAIL_EN
                        state_d = TAIL;
                        tcnt_d  = '0;
`else
                        // Flush step folded into the accepting edge.
                        last_d  = 1'b1;
                        sr_d    = '0;
                        state_d = DRAIN;
`endif
                    end
                end
            end
`ifdef CONV_TAIL_EN
            TAIL: begin
                if (out_free) begin
                    c0_d        = ^(enc_v & G0);
                    c1_d        = ^(enc_v & G1);
                    out_valid_d = 1'b1;
                    last_d      = 1'b0;
                    sr_d        = {1'b0, sr_q[K-2:1]};
                    tcnt_d      = tcnt_q + TW'(1);
                    if (tcnt_q == TW'(K - 2)) begin
                        last_d  = 1'b1;
                        sr_d    = '0;
                        tcnt_d  = '0;
                        state_d = DRAIN;
                    end
                end
            end
`endif
            DRAIN: begin
                if (out_valid_q && out_ready && last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            c0_q        <= 1'b0;
            c1_q        <= 1'b0;
            last_q      <= 1'b0;
`ifdef CONV_TAIL_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            last_q      <= last_d;
`ifdef CONV_TAIL_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign c0        = c0_q;
    assign c1        = c1_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Bench for conv_encoder_stream: directed frame table, corner sequences, randomized frames vs a convolution model.
module tb_conv_encoder_stream;

`ifdef CONV_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid, in_ready, b0, in_last, out_valid, out_ready, c0, c1, out_last, busy;
    logic in_valid7, in_ready7, b07, in_last7, out_valid7, out_ready7, c07, c17, out_last7, busy7;

    conv_encoder_stream #(.K(3), .G0(3'b111), .G1(3'b101)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .b0(b0),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .c0(c0), .c1(c1),
        .out_last(out_last), .busy(busy)
    );

    conv_encoder_stream #(.K(7), .G0(7'b1111001), .G1(7'b1011011)) dut7 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .b0(b07),
        .in_last(in_last7), .out_valid(out_valid7), .out_ready(out_ready7), .c0(c07), .c1(c17),
        .out_last(out_last7), .busy(busy7)
    );

    int tests = 0;
    int fails = 0;

    bit         tx_q[$];
    logic [2:0] rx_q[$];
    logic [2:0] exp_q[$];
    int first_acc, first_vld, first_rx, last_rx, stall_err, hold_err, busy_err, stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each code bit is the GF(2) convolution of the frame bits with the generator taps.
    function automatic void model(input int k, input logic [31:0] g0, input logic [31:0] g1, input bit tail);
        bit s[$];
        s = tx_q;
        if (tail) for (int i = 0; i < k - 1; i++) s.push_back(1'b0);
        exp_q.delete();
        for (int t = 0; t < s.size(); t++) begin
            bit a, b;
            a = 1'b0;
            b = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (t - j >= 0) begin
                    a ^= g0[k-1-j] & s[t-j];
                    b ^= g1[k-1-j] & s[t-j];
                end
            end
            exp_q.push_back({a, b, (t == s.size() - 1)});
        end
    endfunction

    task automatic compare(input string tag);
        check($sformatf("%s_len", tag), rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_pair%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input int bp_pct, input int gap_pct, input int stall_at);
        int idx;
        int cyc;
        bit done;
        bit held;
        logic [2:0] hold_val;
        idx = 0; cyc = 0; done = 1'b0; held = 1'b0; hold_val = '0;
        rx_q.delete();
        first_acc = -1; first_vld = -1; first_rx = -1; last_rx = -1;
        stall_err = 0; hold_err = 0; busy_err = 0; stalls = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            if (held && (!out_valid || {c0, c1, out_last} !== hold_val)) hold_err++;
            in_valid  = (idx < tx_q.size()) && ($urandom_range(99) >= gap_pct);
            b0        = in_valid ? tx_q[idx] : 1'b0;
            in_last   = in_valid && (idx == tx_q.size() - 1);
            out_ready = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3) ? 1'b0
                        : ($urandom_range(99) >= bp_pct);
            #1;
            if (first_acc >= 0 && !busy) busy_err++;
            if (out_valid && first_vld < 0) first_vld = cyc;
            held = out_valid && !out_ready;
            hold_val = {c0, c1, out_last};
            if (held) begin
                stalls++;
                if (in_ready) stall_err++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (out_valid && out_ready) begin
                rx_q.push_back({c0, c1, out_last});
                if (first_rx < 0) first_rx = cyc;
                last_rx = cyc;
                if (out_last) done = 1'b1;
            end
            cyc++;
        end
        check("frame_done", done, 1);
        check("stall_in_ready", stall_err, 0);
        check("hold_stable", hold_err, 0);
        check("busy_in_frame", busy_err, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("end_busy", busy, 0);
        check("end_in_ready", in_ready, 1);
    endtask

    typedef struct {
        int         n;
        logic [7:0] bits;
        int         stall_at;
        logic [15:0] exp_t;
        logic [15:0] exp_n;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] pk;
        logic [6:0]  g0c, g1c;
        int np, idx;

        vecs[0] = '{n: 4, bits: 8'h0D, stall_at: -1, exp_t: 16'h0D4B, exp_n: 16'h004B};
        vecs[1] = '{n: 3, bits: 8'h07, stall_at: -1, exp_t: 16'h0367, exp_n: 16'h0027};
        vecs[2] = '{n: 1, bits: 8'h01, stall_at: -1, exp_t: 16'h003B, exp_n: 16'h0003};
        vecs[3] = '{n: 1, bits: 8'h00, stall_at: -1, exp_t: 16'h0000, exp_n: 16'h0000};
        vecs[4] = '{n: 4, bits: 8'h0D, stall_at: 2,  exp_t: 16'h0D4B, exp_n: 16'h004B};

        rst_n = 1'b0;
        in_valid = 1'b0; b0 = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_valid7 = 1'b0; b07 = 1'b0; in_last7 = 1'b0; out_ready7 = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_code", {c0, c1, out_last}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            tx_q.delete();
            for (int i = 0; i < vecs[v].n; i++) tx_q.push_back(vecs[v].bits[i]);
            np = TAIL_EN ? vecs[v].n + 2 : vecs[v].n;
            pk = TAIL_EN ? vecs[v].exp_t : vecs[v].exp_n;
            exp_q.delete();
            for (int i = 0; i < np; i++) exp_q.push_back({pk[2*i+1], pk[2*i], (i == np - 1)});
            run_frame(0, 0, vecs[v].stall_at);
            compare($sformatf("vec%0d", v));
            if (vecs[v].stall_at < 0) begin
                check($sformatf("vec%0d_latency", v), first_vld - first_acc, 1);
                check($sformatf("vec%0d_throughput", v), last_rx - first_rx, np - 1);
            end else begin
                check($sformatf("vec%0d_stalled", v), (stalls >= 3), 1);
            end
        end

        // Reset in the middle of frame termination, then a clean single-bit frame.
        tx_q.delete();
        tx_q.push_back(1'b1);
        tx_q.push_back(1'b1);
        idx = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            b0 = tx_q[idx];
            in_last = (idx == 1);
            #1;
            if (in_ready) idx++;
        end
        check("rst_seq_sent", idx, 2);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_pair", {out_valid, c0, c1}, 3'b101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_code", {c0, c1, out_last}, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        tx_q.push_back(1'b0);
        model(3, 32'b111, 32'b101, TAIL_EN);
        run_frame(0, 0, -1);
        compare("post_rst");

        for (int f = 0; f < 30; f++) begin
            tx_q.delete();
            np = $urandom_range(12, 1);
            for (int i = 0; i < np; i++) tx_q.push_back($urandom_range(1));
            model(3, 32'b111, 32'b101, TAIL_EN);
            run_frame(30, 20, -1);
            compare($sformatf("rnd%0d", f));
        end

        // K=7 impulse response on the second instance.
        tx_q.delete();
        tx_q.push_back(1'b1);
        if (!TAIL_EN) for (int i = 0; i < 6; i++) tx_q.push_back(1'b0);
        rx_q.delete();
        idx = 0;
        out_ready7 = 1'b1;
        begin
            bit done7;
            done7 = 1'b0;
            for (int c = 0; c < 200 && !done7; c++) begin
                @(negedge clk);
                in_valid7 = (idx < tx_q.size());
                b07 = in_valid7 ? tx_q[idx] : 1'b0;
                in_last7 = in_valid7 && (idx == tx_q.size() - 1);
                #1;
                if (in_valid7 && in_ready7) idx++;
                if (out_valid7) begin
                    rx_q.push_back({c07, c17, out_last7});
                    done7 = out_last7;
                end
            end
            check("k7_done", done7, 1);
        end
        in_valid7 = 1'b0;
        model(7, 32'b1111001, 32'b1011011, TAIL_EN);
        compare("k7");
        g0c = 7'b1111001;
        g1c = 7'b1011011;
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            check($sformatf("k7_c0_%0d", i), rx_q[i][2], g0c[6-i]);
            check($sformatf("k7_c1_%0d", i), rx_q[i][1], g1c[6-i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
